// File: rtl/wasm_const_decoder_pkg.sv
// Shared opcodes, value types, error codes and FSM states for the
// WebAssembly constant-instruction decoder.
package wasm_const_pkg;

    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    typedef enum logic [1:0] {
        TYPE_I32 = 2'd0,
        TYPE_I64 = 2'd1,
        TYPE_F32 = 2'd2,
        TYPE_F64 = 2'd3
    } const_type_t;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_BAD_OPCODE = 4'd1,
        ERR_LEB_LONG   = 4'd2,
        ERR_LEB_PAD    = 4'd3
    } const_err_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEB,
        S_RAW,
        S_OUT,
        S_ERR
    } state_t;

endpackage

// File: rtl/wasm_const_decoder_if.sv
// Byte-in / constant-out handshake bundle of the constant decoder.
interface wasm_const_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_value;
    logic [1:0]  out_type;
    logic        error;
    logic [3:0]  error_code;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_value, out_type, error, error_code
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_value, out_type, error, error_code
    );
endinterface

// File: rtl/wasm_const_decoder_leb128_acc.sv
// Registered LEB128 accumulator; in raw mode the same register collects
// little-endian bytes for the float immediates.
module wasm_leb128_acc #(
    parameter bit STRICT_LEB = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_en,
    input  logic        raw,
    input  logic        width64,
    input  logic [7:0]  data_byte,
    output logic [63:0] value,
    output logic        done,
    output logic        err_long,
    output logic        err_pad
);
    logic [63:0] acc, acc_next, ext;
    logic [6:0]  shift, shift_next;
    logic [3:0]  count, count_inc, limit, raw_len;
    logic        at_limit, pad_bad;

    always_comb begin
        count_inc  = count + 4'd1;
        shift_next = shift + 7'd7;
        limit      = width64 ? 4'd10 : 4'd5;
        raw_len    = width64 ? 4'd8 : 4'd4;
        at_limit   = (count_inc == limit);
        pad_bad    = width64 ? (data_byte[6:1] != {6{data_byte[0]}})
                             : (data_byte[6:4] != {3{data_byte[3]}});
        acc_next   = acc;
        ext        = '1;
        done       = 1'b0;
        err_long   = 1'b0;
        err_pad    = 1'b0;
        if (raw) begin
            acc_next[{count[2:0], 3'b000} +: 8] = data_byte;
            done = (count_inc == raw_len);
        end else begin
            acc_next = acc | ({57'd0, data_byte[6:0]} << shift);
            if (!data_byte[7]) begin
                // Sign fill starts right above the last payload bit.
                if (data_byte[6] && (shift_next < (width64 ? 7'd64 : 7'd32))) begin
                    ext      = ext << shift_next;
                    acc_next = acc_next | ext;
                end
                if (!width64) acc_next[63:32] = '0;
                done    = 1'b1;
                err_pad = STRICT_LEB && at_limit && pad_bad;
            end else begin
                err_long = at_limit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            shift <= '0;
            count <= '0;
        end else if (start) begin
            acc   <= '0;
            shift <= '0;
            count <= '0;
        end else if (byte_en) begin
            acc   <= acc_next;
            shift <= shift_next;
            count <= count_inc;
        end
    end

    assign value = acc;
endmodule

// File: rtl/wasm_const_decoder.sv
// Streaming decoder for i32/i64/f32/f64.const: opcode plus immediate in,
// one typed 64-bit constant out.
module wasm_const_decoder
    import wasm_const_pkg::*;
#(
    parameter bit ENABLE_64  = 1'b1,
    parameter bit STRICT_LEB = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    wasm_const_decoder_if.slave  bus
);
    state_t      state, state_next;
    const_type_t type_q, type_next;
    const_err_t  err_q, err_next;
    logic        width64_q, width64_next;
    logic        armed;
    logic        accept, acc_start, acc_byte_en;
    logic [63:0] acc_value;
    logic        acc_done, acc_err_long, acc_err_pad;

    // armed keeps in_ready low until the first edge after reset release.
    assign bus.in_ready   = armed && (state == S_IDLE || state == S_LEB || state == S_RAW);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = (state == S_OUT);
    assign bus.out_value  = acc_value;
    assign bus.out_type   = type_q;
    assign bus.error      = (state == S_ERR);
    assign bus.error_code = err_q;

    wasm_leb128_acc #(.STRICT_LEB(STRICT_LEB)) u_acc (
        .clk       (clk),
        .reset     (reset),
        .start     (acc_start),
        .byte_en   (acc_byte_en),
        .raw       (state == S_RAW),
        .width64   (width64_q),
        .data_byte (bus.in_byte),
        .value     (acc_value),
        .done      (acc_done),
        .err_long  (acc_err_long),
        .err_pad   (acc_err_pad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            type_q    <= TYPE_I32;
            err_q     <= ERR_NONE;
            width64_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_next;
            type_q    <= type_next;
            err_q     <= err_next;
            width64_q <= width64_next;
            armed     <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        type_next    = type_q;
        err_next     = err_q;
        width64_next = width64_q;
        acc_start    = 1'b0;
        acc_byte_en  = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                acc_start = 1'b1;
                case (bus.in_byte)
                    OP_I32_CONST: begin
                        state_next = S_LEB; type_next = TYPE_I32; width64_next = 1'b0;
                    end
                    OP_I64_CONST: if (ENABLE_64) begin
                        state_next = S_LEB; type_next = TYPE_I64; width64_next = 1'b1;
                    end else begin
                        state_next = S_ERR; err_next = ERR_BAD_OPCODE;
                    end
                    OP_F32_CONST: begin
                        state_next = S_RAW; type_next = TYPE_F32; width64_next = 1'b0;
                    end
                    OP_F64_CONST: if (ENABLE_64) begin
                        state_next = S_RAW; type_next = TYPE_F64; width64_next = 1'b1;
                    end else begin
                        state_next = S_ERR; err_next = ERR_BAD_OPCODE;
                    end
                    default: begin
                        state_next = S_ERR; err_next = ERR_BAD_OPCODE;
                    end
                endcase
            end
            S_LEB, S_RAW: if (accept) begin
                acc_byte_en = 1'b1;
                if (acc_err_long) begin
                    state_next = S_ERR; err_next = ERR_LEB_LONG;
                end else if (acc_err_pad) begin
                    state_next = S_ERR; err_next = ERR_LEB_PAD;
                end else if (acc_done) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: if (bus.out_ready) state_next = S_IDLE;
            S_ERR: state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_wasm_const_decoder.sv
// Bench for wasm_const_decoder: directed vector table, hand-written reset and
// error sequences, and random instructions against a value-level model.
module tb_wasm_const_decoder;
    logic clk = 1'b0;
    logic reset;
    logic in_valid, out_ready;
    logic [7:0] in_byte;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wasm_const_decoder_if bus_a();
    wasm_const_decoder_if bus_b();
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_byte = in_byte;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_byte = in_byte;
    assign bus_b.out_ready = out_ready;

    wasm_const_decoder #(.ENABLE_64(1'b1), .STRICT_LEB(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    wasm_const_decoder #(.ENABLE_64(1'b0), .STRICT_LEB(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    logic sel_b = 1'b0;
    logic m_in_ready, m_out_valid, m_error;
    logic [63:0] m_out_value;
    logic [1:0] m_out_type;
    logic [3:0] m_error_code;
    assign m_in_ready   = sel_b ? bus_b.in_ready   : bus_a.in_ready;
    assign m_out_valid  = sel_b ? bus_b.out_valid  : bus_a.out_valid;
    assign m_out_value  = sel_b ? bus_b.out_value  : bus_a.out_value;
    assign m_out_type   = sel_b ? bus_b.out_type   : bus_a.out_type;
    assign m_error      = sel_b ? bus_b.error      : bus_a.error;
    assign m_error_code = sel_b ? bus_b.error_code : bus_a.error_code;

    typedef struct {
        logic [0:10][7:0] b;
        int               n;
        bit               ok;
        logic [63:0]      val;
        logic [1:0]       typ;
        logic [3:0]       code;
        bit               use_b;
        int               stall;
    } vec_t;
    vec_t tv[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Reference: decode one instruction from its byte image by arithmetic on
    // the numeric value (signed range check stands in for padding rules).
    function automatic void model(input logic [0:10][7:0] b, output bit ok,
                                  output logic [63:0] val, output logic [1:0] typ,
                                  output logic [3:0] code, output int used);
        logic [127:0] raw, hi, ones;
        int w, lim;
        ok = 1'b0; val = '0; typ = 2'd0; code = 4'd0; used = 1;
        if (b[0] == 8'h41 || b[0] == 8'h42) begin
            w   = (b[0] == 8'h41) ? 32 : 64;
            lim = (b[0] == 8'h41) ? 5 : 10;
            typ = (b[0] == 8'h41) ? 2'd0 : 2'd1;
            raw = '0;
            for (int i = 1; i <= lim; i++) begin
                raw = raw + ({121'd0, b[i][6:0]} << (7 * (i - 1)));
                if (!b[i][7]) begin
                    if (b[i][6]) raw = raw - (128'd1 << (7 * i));
                    hi = raw >> (w - 1);
                    ones = '1;
                    ones = ones >> (w - 1);
                    used = i + 1;
                    if (hi != '0 && hi != ones) code = 4'd3;
                    else begin
                        ok  = 1'b1;
                        val = raw[63:0] & ((w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
                    end
                    return;
                end
            end
            used = lim + 1;
            code = 4'd2;
        end else if (b[0] == 8'h43 || b[0] == 8'h44) begin
            lim = (b[0] == 8'h43) ? 4 : 8;
            typ = (b[0] == 8'h43) ? 2'd2 : 2'd3;
            for (int i = 1; i <= lim; i++) val = val + ({56'd0, b[i]} << (8 * (i - 1)));
            ok = 1'b1;
            used = lim + 1;
        end else begin
            code = 4'd1;
        end
    endfunction

    task automatic run_instr(input logic [0:10][7:0] b, input int n, input bit ok,
                             input logic [63:0] exp_val, input logic [1:0] exp_typ,
                             input logic [3:0] exp_code, input int gaps_max, input int stall);
        bit early;
        int gap, k;
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            gap = (gaps_max > 0) ? int'($urandom_range(gaps_max, 0)) : 0;
            repeat (gap) begin in_byte = 8'($urandom); @(negedge clk); end
            k = 0;
            while (!m_in_ready && k < 10) begin @(negedge clk); k++; end
            if (!m_in_ready) begin
                check("in_ready_timeout", 64'(m_in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (m_out_valid || m_error) early = 1'b1;
            in_valid = 1'b1; in_byte = b[i];
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("no_early_result", 64'(early), 64'd0);
        if (ok) begin
            check("out_valid", 64'(m_out_valid), 64'd1);
            check("out_value", m_out_value, exp_val);
            check("out_type", 64'(m_out_type), 64'(exp_typ));
            check("in_ready_in_out", 64'(m_in_ready), 64'd0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("hold_valid", 64'(m_out_valid), 64'd1);
                check("hold_value", m_out_value, exp_val);
                check("hold_type", 64'(m_out_type), 64'(exp_typ));
                check("hold_in_ready", 64'(m_in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("drained", 64'(m_out_valid), 64'd0);
        end else begin
            check("error", 64'(m_error), 64'd1);
            check("error_code", 64'(m_error_code), 64'(exp_code));
            check("in_ready_in_err", 64'(m_in_ready), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{88'h43_00_00_00_C0_00_00_00_00_00_00, 5,  1, 64'h0000_0000_C000_0000, 2'd2, 4'd0, 0, 0};
        tv[1]  = '{88'h41_7F_00_00_00_00_00_00_00_00_00, 2,  1, 64'h0000_0000_FFFF_FFFF, 2'd0, 4'd0, 0, 0};
        tv[2]  = '{88'h42_80_7F_00_00_00_00_00_00_00_00, 3,  1, 64'hFFFF_FFFF_FFFF_FF80, 2'd1, 4'd0, 0, 1};
        tv[3]  = '{88'h44_00_00_00_00_00_00_F0_3F_00_00, 9,  1, 64'h3FF0_0000_0000_0000, 2'd3, 4'd0, 0, 3};
        tv[4]  = '{88'h41_FF_FF_FF_FF_7F_00_00_00_00_00, 6,  1, 64'h0000_0000_FFFF_FFFF, 2'd0, 4'd0, 0, 0};
        tv[5]  = '{88'h41_FF_FF_FF_FF_0F_00_00_00_00_00, 6,  0, 64'd0, 2'd0, 4'd3, 0, 0};
        tv[6]  = '{88'h41_80_80_80_80_80_00_00_00_00_00, 6,  0, 64'd0, 2'd0, 4'd2, 0, 0};
        tv[7]  = '{88'h45_00_00_00_00_00_00_00_00_00_00, 1,  0, 64'd0, 2'd0, 4'd1, 0, 0};
        tv[8]  = '{88'h42_00_00_00_00_00_00_00_00_00_00, 1,  0, 64'd0, 2'd0, 4'd1, 1, 0};
        tv[9]  = '{88'h44_00_00_00_00_00_00_00_00_00_00, 1,  0, 64'd0, 2'd0, 4'd1, 1, 0};
        tv[10] = '{88'h42_FF_FF_FF_FF_FF_FF_FF_FF_FF_7F, 11, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 4'd0, 0, 0};
        tv[11] = '{88'h42_80_80_80_80_80_80_80_80_80_7F, 11, 1, 64'h8000_0000_0000_0000, 2'd1, 4'd0, 0, 2};
        tv[12] = '{88'h42_80_80_80_80_80_80_80_80_80_01, 11, 0, 64'd0, 2'd0, 4'd3, 0, 0};
        tv[13] = '{88'h41_80_80_80_80_78_00_00_00_00_00, 6,  1, 64'h0000_0000_8000_0000, 2'd0, 4'd0, 0, 0};
        tv[14] = '{88'h41_E5_8E_26_00_00_00_00_00_00_00, 4,  1, 64'h0000_0000_0009_8765, 2'd0, 4'd0, 0, 0};
        tv[15] = '{88'h42_80_80_80_80_80_80_80_80_80_80, 11, 0, 64'd0, 2'd0, 4'd2, 0, 0};

        // Reset state, observed both during and after reset.
        in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00; reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready_held", 64'(m_in_ready), 64'd0);
        check("rst_out_valid", 64'(m_out_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(m_in_ready), 64'd1);
        check("rst_out_value", m_out_value, 64'd0);
        check("rst_out_type", 64'(m_out_type), 64'd0);
        check("rst_error", 64'(m_error), 64'd0);
        check("rst_error_code", 64'(m_error_code), 64'd0);

        foreach (tv[i]) begin
            sel_b = tv[i].use_b;
            do_reset();
            run_instr(tv[i].b, tv[i].n, tv[i].ok, tv[i].val, tv[i].typ, tv[i].code, 0, tv[i].stall);
        end
        sel_b = 1'b0;

        // Error state absorbs further traffic.
        do_reset();
        run_instr(88'h45_00_00_00_00_00_00_00_00_00_00, 1, 0, 64'd0, 2'd0, 4'd1, 0, 0);
        in_valid = 1'b1; in_byte = 8'h41;
        repeat (5) begin
            @(negedge clk);
            check("err_absorb_ready", 64'(m_in_ready), 64'd0);
            check("err_absorb_code", 64'(m_error_code), 64'd1);
        end
        in_valid = 1'b0;

        // Asynchronous reset in the middle of an f32 immediate.
        do_reset();
        in_valid = 1'b1; in_byte = 8'h43; @(negedge clk);
        in_byte = 8'h11; @(negedge clk);
        in_byte = 8'h22; @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_acc", m_out_value, 64'h0000_0000_0000_2211);
        #2 reset = 1'b1;
        #1;
        check("async_value", m_out_value, 64'd0);
        check("async_type", 64'(m_out_type), 64'd0);
        check("async_valid", 64'(m_out_valid), 64'd0);
        check("async_error", 64'(m_error), 64'd0);
        check("async_in_ready", 64'(m_in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_instr(88'h43_00_00_80_3F_00_00_00_00_00_00, 5, 1, 64'h0000_0000_3F80_0000, 2'd2, 4'd0, 0, 0);

        // Random instruction stream with input gaps and output stalls.
        do_reset();
        for (int t = 0; t < 200; t++) begin
            logic [0:10][7:0] b;
            logic [63:0] v;
            logic [1:0] ty;
            logic [3:0] c;
            bit ok, longseq;
            int pick, lim, len, used;
            b = '0;
            pick = int'($urandom_range(15, 0));
            if (pick == 0) begin
                b[0] = 8'($urandom);
                if (b[0] >= 8'h41 && b[0] <= 8'h44) b[0] = 8'h45;
            end else begin
                b[0] = 8'h41 + 8'(pick % 4);
            end
            if (b[0] == 8'h41 || b[0] == 8'h42) begin
                lim = (b[0] == 8'h41) ? 5 : 10;
                longseq = ($urandom_range(7, 0) == 0);
                len = (longseq || $urandom_range(3, 0) == 0) ? lim : int'($urandom_range(lim, 1));
                for (int i = 1; i <= len; i++) begin
                    b[i] = 8'($urandom);
                    b[i][7] = (i < len) || longseq;
                end
                if (!longseq && len == lim && $urandom_range(3, 0) != 0) begin
                    if (lim == 5) b[len][6:4] = {3{b[len][3]}};
                    else          b[len][6:1] = {6{b[len][0]}};
                end
            end else if (b[0] == 8'h43 || b[0] == 8'h44) begin
                for (int i = 1; i <= 8; i++) b[i] = 8'($urandom);
            end
            model(b, ok, v, ty, c, used);
            run_instr(b, used, ok, v, ty, c, 2, int'($urandom_range(2, 0)));
            if (!ok) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wasm_const_decoder.md
# wasm_const_decoder

Streaming decoder for the four WebAssembly constant instructions: i32.const, i64.const, f32.const and f64.const. It consumes an opcode byte followed by its immediate, one byte per cycle, over a valid/ready handshake. It emits a typed 64-bit value for the operand stack. It sits between the instruction fetch byte stream (fed from genrom) and the core's operand push path, and replaces ad-hoc immediate handling inside `core`.

## Interface
Parameters:
- `ENABLE_64`, default 1: when 0, opcodes 0x42 and 0x44 are rejected as unsupported.
- `STRICT_LEB`, default 1: when 1, padding bits of the final LEB128 byte are checked.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_byte` is valid.
- `in_ready` out 1: decoder accepts `in_byte` this cycle.
- `in_byte` in 8: opcode or immediate byte.
- `out_valid` out 1: decoded constant available.
- `out_ready` in 1: consumer takes the constant.
- `out_value` out 64: constant value.
  - 32-bit types occupy bits [31:0]; bits [63:32] are 0.
- `out_type` out 2: 0 = i32, 1 = i64, 2 = f32, 3 = f64.
- `error` out 1: sticky decode error.
- `error_code` out 4: 0 = none, 1 = bad or unsupported opcode, 2 = LEB too long, 3 = LEB padding mismatch.

## Operation
- A byte transfers when `in_valid && in_ready`. A value transfers when `out_valid && out_ready`.
- States:
  - IDLE: `in_ready`=1.
  - LEB: `in_ready`=1.
  - RAW: `in_ready`=1.
  - OUT: `in_ready`=0, `out_valid`=1.
  - ERR: `in_ready`=0, `error`=1.
- IDLE, opcode accepted:
  - 0x41 → LEB, limit 5 bytes, width 32.
  - 0x42 → LEB, limit 10 bytes, width 64.
  - 0x43 → RAW, 4 bytes.
  - 0x44 → RAW, 8 bytes.
  - Any other opcode, or 0x42/0x44 with `ENABLE_64`=0 → ERR, code 1.
  - On the transition the accumulator, shift and byte count clear.
- LEB, per accepted byte b:
  - `acc |= b[6:0] << shift`; `shift += 7`; `count += 1`.
  - If b[7]=0: when b[6]=1 and shift < width, sign-extend acc from bit `shift`. Truncate to width, then go to OUT.
  - If b[7]=1 and count == limit → ERR, code 2.
- STRICT_LEB padding check on the final byte at limit:
  - i32, byte 5: b[6:4] must equal b[3].
  - i64, byte 10: b[6:1] must equal b[0].
  - Violation → ERR, code 3 instead of OUT.
- RAW, little-endian: `acc[8*count +: 8] = b`. When count reaches 4 or 8 → OUT.
- OUT:
  - `out_value` and `out_type` are stable while `out_valid`=1 and `out_ready`=0.
  - On transfer → IDLE.
- ERR is absorbing until `reset`.
- Reset, asynchronous, at any time including mid-immediate:
  - State → IDLE; accumulator, counters, `out_value`, `out_type`, `error_code` → 0.
  - `out_valid`=0, `error`=0.
  - `in_ready`=1 from the first clock edge after deassertion.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.
- `out_valid` rises on the cycle after the last immediate byte is accepted.
  - Minimum instruction latency is opcode + N bytes + 1 cycle.
  - f32.const with contiguous `in_valid` gives `out_valid` 5 cycles after the opcode transfer.
- After the output transfer, IDLE is entered on the next edge. The next opcode is accepted no earlier than one cycle after `out_valid` falls. Back-to-back throughput is therefore N+2 cycles per constant.
- Gaps with `in_valid`=0 stall any state without side effects.
- `error` and `error_code` rise on the edge that accepts the offending byte.

## Structure
- `wasm_const_pkg` holds:
  - opcode localparams `OP_I32_CONST`..`OP_F64_CONST`;
  - `const_type_t` enum (2 bits);
  - `const_err_t` enum (4 bits);
  - `state_t` enum.
- Sub-module `wasm_leb128_acc` is the registered LEB128 accumulator. It has `start`, `byte_en`, `byte`, `width64` inputs and `value`, `done`, `err_long`, `err_pad` outputs. The top-level FSM reuses its register for the RAW byte shift.
- Target size: 150–300 lines total.

## Test plan
- 43 00 00 00 C0, `out_ready`=1 → `out_valid` 5 cycles after the opcode; `out_value`=0x00000000_C0000000, `out_type`=2.
- 41 7F → `out_value`=0x00000000_FFFFFFFF, `out_type`=0. Then 42 80 7F → 0xFFFFFFFF_FFFFFF80, `out_type`=1.
- 44 00 00 00 00 00 00 F0 3F with `out_ready` held low 3 cycles → `out_value`=0x3FF00000_00000000 and `out_type`=3, stable for all 4 `out_valid` cycles. `in_ready`=0 throughout.
- 41 FF FF FF FF 7F → 0x00000000_FFFFFFFF. 41 FF FF FF FF 0F → `error`=1, code 3. 41 80 80 80 80 80 → code 2 on the 5th immediate byte.
- Opcode 0x45 → `error`=1, code 1, `in_ready`=0 indefinitely. Repeat 0x42 with `ENABLE_64`=0 → code 1.
- `reset` asserted between the 2nd and 3rd bytes of 43 … → all outputs 0 immediately. Afterwards 43 00 00 80 3F decodes to 0x00000000_3F800000 with no residue.
